// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: alu_control op codes, sequencer states,
// and the divide-by-zero Lo value.
package mdu_pkg;

   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_MADD  = 6'b011100;
   localparam logic [5:0] OP_MADDU = 6'b011101;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MTLO  = 6'b010011;

   localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

endpackage

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MADD/DIV sequencer owning Hi/Lo. One shared 64-bit working
// register, one WIDTH+1 bit adder/subtractor, WIDTH iterations plus a fix-up cycle.
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             ready,
   input  logic [5:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] work, work_nxt;
   logic [WIDTH-1:0]   opnd;
   logic               neg_lo, neg_hi, acc_en, div_op, div0;

   logic               is_mul, is_div, is_sgn, accept, iter_last;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     add_x, add_y, add_s;
   logic               add_sub, qbit;
   logic [WIDTH-1:0]   rem_nxt, quot_s, rem_s;
   logic [2*WIDTH-1:0] prod, fix_res;

   always_comb begin
      is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU);
      is_div = (op == OP_DIV) || (op == OP_DIVU);
      is_sgn = (op == OP_MULT) || (op == OP_MADD) || (op == OP_DIV);
      a_neg  = is_sgn && a[WIDTH-1];
      b_neg  = is_sgn && b[WIDTH-1];
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
   end

   assign ready     = (state == S_IDLE);
   assign accept    = start && ready && !cancel;
   assign iter_last = (cnt == LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept && is_mul)      state_nxt = S_MUL;
            else if (accept && is_div) state_nxt = S_DIV;
         end
         S_MUL, S_DIV: begin
            if (cancel)         state_nxt = S_IDLE;
            else if (iter_last) state_nxt = S_FIX;
         end
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // MUL: work = {acc, multiplier}, shift right with carry-in from the adder.
   // DIV: work = {rem, quot}, shift left and trial-subtract the divisor; the
   // partial remainder stays below the divisor, so bit WIDTH is the sign.
   always_comb begin
      add_sub = (state == S_DIV);
      add_x   = add_sub ? work[2*WIDTH-1:WIDTH-1] : {1'b0, work[2*WIDTH-1:WIDTH]};
      add_y   = add_sub ? ~{1'b0, opnd} : {1'b0, opnd};
      add_s   = add_x + add_y + {{WIDTH{1'b0}}, add_sub};
      qbit    = ~add_s[WIDTH];
      rem_nxt = qbit ? add_s[WIDTH-1:0] : work[2*WIDTH-2:WIDTH-1];
      work_nxt = work;
      if (state == S_MUL)
         work_nxt = work[0] ? {add_s, work[WIDTH-1:1]} : {1'b0, work[2*WIDTH-1:1]};
      else if (state == S_DIV)
         work_nxt = {rem_nxt, work[WIDTH-2:0], qbit};
   end

   always_comb begin
      prod    = neg_lo ? -work : work;
      quot_s  = neg_lo ? -work[WIDTH-1:0] : work[WIDTH-1:0];
      rem_s   = neg_hi ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
      fix_res = prod + (acc_en ? {hi, lo} : {(2*WIDTH){1'b0}});
      // A zero divisor leaves the dividend as remainder; only Lo needs forcing.
      if (div_op)
         fix_res = {rem_s, div0 ? DIV0_LO[WIDTH-1:0] : quot_s};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         work   <= '0;
         opnd   <= '0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         acc_en <= 1'b0;
         div_op <= 1'b0;
         div0   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != S_IDLE);
         done  <= (state == S_FIX) && !cancel;
         work  <= work_nxt;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (accept) begin
                  if (is_mul || is_div) begin
                     work   <= {{WIDTH{1'b0}}, is_mul ? b_mag : a_mag};
                     opnd   <= is_mul ? a_mag : b_mag;
                     neg_lo <= a_neg ^ b_neg;
                     neg_hi <= a_neg;
                     acc_en <= (op == OP_MADD) || (op == OP_MADDU);
                     div_op <= is_div;
                     div0   <= is_div && (b == '0);
                  end
                  if (op == OP_MTHI) hi <= a;
                  if (op == OP_MTLO) lo <= a;
               end
            end
            S_MUL, S_DIV: cnt <= cnt + 1'b1;
            S_FIX: begin
               if (!cancel) begin
                  hi <= fix_res[2*WIDTH-1:WIDTH];
                  lo <= fix_res[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed ops push expected Hi/Lo, a
// negedge monitor checks value, latency, busy window and done width on each done.
module tb_mdu_sequencer;
   import mdu_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, cancel = 1'b0;
   logic [5:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        ready, busy, done;
   logic [31:0] hi, lo;

   always #5 clk = ~clk;

   mdu_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .op(op),
      .a(a), .b(b), .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          t0;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_cmp = 0, n_bad = 0, cyc = 0, run = 0, last_acc = 0, prev_acc = 0;
   logic last_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk(name, {32'b0, act}, {32'b0, exp});
   endtask

   always @(negedge clk) begin
      if (last_done) chk("done_width", {63'b0, done}, 64'd0);
      last_done = done;
      if (busy) run++;
      else begin
         if (done) begin
            if (sbq.size() == 0) chk("unexpected_done", {63'b0, done}, 64'd0);
            else begin
               mon_e = sbq.pop_front();
               chk({mon_e.name, "_hilo"}, {hi, lo}, {mon_e.hi, mon_e.lo});
               chk({mon_e.name, "_latency"}, 64'(cyc - mon_e.t0), 64'd33);
               chk({mon_e.name, "_busy_cycles"}, 64'(run), 64'd33);
            end
         end
         run = 0;
      end
   end

   task automatic issue(input string name, input logic [5:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit expect_res,
                        input logic [31:0] eh, input logic [31:0] el);
      int g = 0;
      start = 1'b1; op = o; a = x; b = y;
      while (!ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk({name, "_ready_wait"}, {63'b0, ready}, 64'd1);
      @(posedge clk);
      #1;
      prev_acc = last_acc;
      last_acc = cyc;
      if (expect_res) sbq.push_back('{name, eh, el, cyc});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((busy || done || sbq.size() != 0) && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("idle_wait", {63'b0, busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk32("rst_hi", hi, 32'h0);
      chk32("rst_lo", lo, 32'h0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_done", {63'b0, done}, 64'd0);
      chk("rst_ready", {63'b0, ready}, 64'd1);
      rst_n = 1'b1;
      @(negedge clk);

      issue("mult", OP_MULT, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFFF, 32'hFFFFFFEB);
      issue("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001);
      issue("maddu", OP_MADDU, 32'd1, 32'd1, 1, 32'hFFFFFFFE, 32'h00000002);
      issue("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD);
      issue("divu", OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14);
      issue("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000);
      issue("divu_zero", OP_DIVU, 32'h10, 32'h0, 1, 32'h10, 32'hFFFFFFFF);
      issue("div_zero_neg", OP_DIV, 32'hFFFFFFFB, 32'h0, 1, 32'hFFFFFFFB, 32'hFFFFFFFF);
      wait_idle();

      issue("mtlo", OP_MTLO, 32'd5, 32'd0, 0, 32'h0, 32'h0);
      chk32("mtlo_lo", lo, 32'd5);
      issue("mthi", OP_MTHI, 32'd0, 32'd0, 0, 32'h0, 32'h0);
      chk32("mthi_hi", hi, 32'd0);
      issue("madd", OP_MADD, 32'd2, 32'd3, 1, 32'h0, 32'h0000000B);
      wait_idle();

      // A request pulsed mid-operation must be dropped and not disturb the MADD.
      issue("madd_busy", OP_MADD, 32'd3, 32'd4, 1, 32'h0, 32'h00000017);
      repeat (3) @(negedge clk);
      start = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      chk32("ignored_start_hi", hi, 32'h0);

      issue("b2b_1", OP_MULT, 32'd2, 32'd3, 1, 32'h0, 32'd6);
      issue("b2b_2", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h0, 32'd1);
      chk("b2b_spacing", 64'(last_acc - prev_acc), 64'd34);
      wait_idle();

      issue("mthi1", OP_MTHI, 32'd1, 32'd0, 0, 32'h0, 32'h0);
      issue("mtlo2", OP_MTLO, 32'd2, 32'd0, 0, 32'h0, 32'h0);
      issue("mult_cancel", OP_MULT, 32'd5, 32'd5, 0, 32'h0, 32'h0);
      repeat (9) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy", {63'b0, busy}, 64'd0);
      chk("cancel_ready", {63'b0, ready}, 64'd1);
      chk({"cancel", "_hilo"}, {hi, lo}, {32'd1, 32'd2});
      repeat (40) @(negedge clk);
      chk("cancel_hilo_later", {hi, lo}, {32'd1, 32'd2});

      cancel = 1'b1; start = 1'b1; op = OP_MTLO; a = 32'd99;
      @(negedge clk);
      cancel = 1'b0; start = 1'b0;
      chk32("cancel_beats_start_lo", lo, 32'd2);

      issue("mult_rst", OP_MULT, 32'd7, 32'd7, 0, 32'h0, 32'h0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk32("midrst_hi", hi, 32'h0);
      chk32("midrst_lo", lo, 32'h0);
      chk("midrst_busy", {63'b0, busy}, 64'd0);
      chk("midrst_ready", {63'b0, ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_busy", {63'b0, busy}, 64'd0);

      issue("multu_after_rst", OP_MULTU, 32'd6, 32'd7, 1, 32'h0, 32'd42);
      wait_idle();
      chk("queue_empty", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
